// File: rtl/secam_line_sequencer.sv
// SECAM chroma line sequencer: line parity, per-line carrier window and U/V gating.
// Optional build macro SECAM_FRAME_PHASE_ALT_EN alternates the Db/Dr start line per frame.
module secam_line_sequencer #(
  parameter int unsigned H_W           = 11,
  parameter int unsigned V_W           = 10,
  parameter int unsigned CARRIER_START = 96,
  parameter int unsigned ACTIVE_START  = 160,
  parameter int unsigned ACTIVE_END    = 1440,
  parameter int unsigned CARRIER_END   = 1480,
  parameter int unsigned FIRST_LINE    = 23,
  parameter int unsigned LAST_LINE     = 310
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                line_start,
  input  logic                newframe,
  input  logic signed [7:0]   yuv_u_in,
  input  logic signed [7:0]   yuv_v_in,
  output logic                even_line,
  output logic                enabled,
  output logic signed [7:0]   yuv_u,
  output logic signed [7:0]   yuv_v,
  output logic [V_W-1:0]      line_index
);

  if (!((CARRIER_START < ACTIVE_START) && (ACTIVE_START < ACTIVE_END) &&
        (ACTIVE_END < CARRIER_END) && (CARRIER_END < (1 << H_W) - 1))) begin : g_param_check
    $error("secam_line_sequencer: window thresholds must be strictly increasing and below the hcnt maximum");
  end

  localparam logic [H_W-1:0] C_START = H_W'(CARRIER_START);
  localparam logic [H_W-1:0] A_START = H_W'(ACTIVE_START);
  localparam logic [H_W-1:0] A_END   = H_W'(ACTIVE_END);
  localparam logic [H_W-1:0] C_END   = H_W'(CARRIER_END);
  localparam logic [V_W-1:0] L_FIRST = V_W'(FIRST_LINE);
  localparam logic [V_W-1:0] L_LAST  = V_W'(LAST_LINE);

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    ACTIVE,
    POST
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [H_W-1:0]    hcnt;
  logic              frame_phase;
  logic              chroma_line;
  logic              enabled_nx;
  logic signed [7:0] yuv_u_nx;
  logic signed [7:0] yuv_v_nx;

  // Horizontal position; sticks at all-ones so a missing line_start cannot re-trigger the window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt <= '0;
    end else if (line_start) begin
      hcnt <= '0;
    end else if (hcnt != '1) begin
      hcnt <= hcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_index <= '0;
    end else if (newframe) begin
      line_index <= '0;
    end else if (line_start && (line_index != '1)) begin
      line_index <= line_index + 1'b1;
    end
  end

`ifdef SECAM_FRAME_PHASE_ALT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_phase <= 1'b0;
    end else if (newframe) begin
      frame_phase <= ~frame_phase;
    end
  end
`else
  always_comb frame_phase = 1'b0;
`endif

  // Frame start uses the phase from before its own toggle, so the first frame opens on Db.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      even_line <= 1'b1;
    end else if (newframe) begin
      even_line <= ~frame_phase;
    end else if (line_start) begin
      even_line <= ~even_line;
    end
  end

  always_comb chroma_line = (line_index >= L_FIRST) && (line_index <= L_LAST);

  always_comb begin
    state_nx   = state;
    enabled_nx = 1'b0;
    yuv_u_nx   = '0;
    yuv_v_nx   = '0;
    if (line_start) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (chroma_line && (hcnt == C_START)) state_nx = PRE;
        PRE:     if (hcnt == A_START)                  state_nx = ACTIVE;
        ACTIVE:  if (hcnt == A_END)                    state_nx = POST;
        POST:    if (hcnt == C_END)                    state_nx = IDLE;
        default:                                       state_nx = IDLE;
      endcase
    end
    // Outputs follow the next state so they become valid together with it.
    case (state_nx)
      PRE, POST: enabled_nx = 1'b1;
      ACTIVE: begin
        enabled_nx = 1'b1;
        yuv_u_nx   = yuv_u_in;
        yuv_v_nx   = yuv_v_in;
      end
      default: enabled_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      enabled <= 1'b0;
      yuv_u   <= '0;
      yuv_v   <= '0;
    end else begin
      state   <= state_nx;
      enabled <= enabled_nx;
      yuv_u   <= yuv_u_nx;
      yuv_v   <= yuv_v_nx;
    end
  end

endmodule

// File: tb/tb_secam_line_sequencer.sv
// Randomized bench for secam_line_sequencer against a window-arithmetic reference model.
module tb_secam_line_sequencer;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              line_start;
  logic              newframe;
  logic signed [7:0] yuv_u_in;
  logic signed [7:0] yuv_v_in;
  logic              even_line;
  logic              enabled;
  logic signed [7:0] yuv_u;
  logic signed [7:0] yuv_v;
  logic [9:0]        line_index;

  int total = 0;
  int bad   = 0;

  // Reference model: position in line, lines since frame start, frames since reset.
  int                m_p;
  int                m_lines;
  int                m_frames;
  logic              m_en;
  logic              m_even;
  logic [9:0]        m_idx;
  logic signed [7:0] m_u;
  logic signed [7:0] m_v;

  secam_line_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_start (line_start),
    .newframe   (newframe),
    .yuv_u_in   (yuv_u_in),
    .yuv_v_in   (yuv_v_in),
    .even_line  (even_line),
    .enabled    (enabled),
    .yuv_u      (yuv_u),
    .yuv_v      (yuv_v),
    .line_index (line_index)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model across the clock edge, sample 1 ns later.
  task automatic tick(input bit ls, input bit nf, input bit rst);
    bit chroma;
    bit pass;
    int start_even;
    rst_n      = ~rst;
    line_start = ls;
    newframe   = nf;
    yuv_u_in   = 8'($urandom);
    yuv_v_in   = 8'($urandom);
    @(posedge clk);
    if (rst) begin
      m_p = 0; m_lines = 0; m_frames = 0;
    end else begin
      if (ls) begin
        m_p = 0;
        if (nf) begin m_lines = 0; m_frames++; end
        else m_lines++;
      end else if (m_p < 2047) begin
        m_p++;
      end
    end
    m_idx  = (m_lines > 1023) ? 10'd1023 : 10'(m_lines);
    chroma = (m_idx >= 23) && (m_idx <= 310);
    m_en   = !rst && chroma && (m_p >= 97) && (m_p <= 1480);
    pass   = !rst && chroma && (m_p >= 161) && (m_p <= 1440);
    m_u    = pass ? yuv_u_in : 8'sd0;
    m_v    = pass ? yuv_v_in : 8'sd0;
`ifdef SECAM_FRAME_PHASE_ALT_EN
    start_even = (m_frames == 0) ? 1 : (((m_frames - 1) % 2 == 0) ? 1 : 0);
`else
    start_even = 1;
`endif
    m_even = 1'(start_even) ^ 1'(m_lines % 2);
    #1;
  endtask

  task automatic goto_line(input int n);
    tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'($urandom), 1'($urandom), 1'b1);
      total++; if (enabled !== 1'b0) begin bad++; $display("FAIL reset_enabled got=%b want=0", enabled); end
      total++; if (yuv_u !== 8'sd0) begin bad++; $display("FAIL reset_yuv_u got=%0d want=0", yuv_u); end
      total++; if (yuv_v !== 8'sd0) begin bad++; $display("FAIL reset_yuv_v got=%0d want=0", yuv_v); end
      total++; if (even_line !== 1'b1) begin bad++; $display("FAIL reset_even got=%b want=1", even_line); end
      total++; if (line_index !== 10'd0) begin bad++; $display("FAIL reset_line_index got=%0d want=0", line_index); end
    end
    tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_line_window();
    goto_line(30);
    total++; if (line_index !== 10'd30) begin bad++; $display("FAIL window_line_index got=%0d want=30", line_index); end
    for (int c = 0; c < 1600; c++) begin
      tick(1'b0, 1'b0, 1'b0);
      total++; if (enabled !== m_en) begin bad++; $display("FAIL window_enabled p=%0d got=%b want=%b", m_p, enabled, m_en); end
      total++; if (yuv_u !== m_u) begin bad++; $display("FAIL window_yuv_u p=%0d got=%0d want=%0d", m_p, yuv_u, m_u); end
      total++; if (yuv_v !== m_v) begin bad++; $display("FAIL window_yuv_v p=%0d got=%0d want=%0d", m_p, yuv_v, m_v); end
    end
  endtask

  task automatic test_blanked_line();
    goto_line(5);
    for (int c = 0; c < 1600; c++) begin
      tick(1'b0, 1'b0, 1'b0);
      total++; if (enabled !== 1'b0) begin bad++; $display("FAIL blank_enabled p=%0d got=%b want=0", m_p, enabled); end
      total++; if (yuv_u !== 8'sd0 || yuv_v !== 8'sd0) begin bad++; $display("FAIL blank_uv p=%0d got=%0d/%0d want=0/0", m_p, yuv_u, yuv_v); end
    end
  endtask

  task automatic test_parity();
    for (int f = 0; f < 2; f++) begin
      tick(1'b1, 1'b1, 1'b0);
      total++; if (even_line !== m_even) begin bad++; $display("FAIL parity_frame_start f=%0d got=%b want=%b", f, even_line, m_even); end
      for (int l = 0; l < 4; l++) begin
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        total++; if (even_line !== m_even) begin bad++; $display("FAIL parity_even l=%0d got=%b want=%b", l, even_line, m_even); end
        total++; if (line_index !== m_idx) begin bad++; $display("FAIL parity_index l=%0d got=%0d want=%0d", l, line_index, m_idx); end
      end
    end
  endtask

  task automatic test_early_line_start();
    goto_line(40);
    while (m_p < 500) tick(1'b0, 1'b0, 1'b0);
    total++; if (enabled !== 1'b1) begin bad++; $display("FAIL early_active got=%b want=1", enabled); end
    tick(1'b1, 1'b0, 1'b0);
    total++; if (enabled !== 1'b0) begin bad++; $display("FAIL early_cut_enabled got=%b want=0", enabled); end
    total++; if (yuv_u !== 8'sd0) begin bad++; $display("FAIL early_cut_yuv_u got=%0d want=0", yuv_u); end
    for (int c = 0; c < 200; c++) begin
      tick(1'b0, 1'b0, 1'b0);
      total++; if (enabled !== m_en) begin bad++; $display("FAIL early_restart p=%0d got=%b want=%b", m_p, enabled, m_en); end
      total++; if (yuv_u !== m_u) begin bad++; $display("FAIL early_yuv_u p=%0d got=%0d want=%0d", m_p, yuv_u, m_u); end
    end
  endtask

  task automatic test_reset_mid_active();
    goto_line(40);
    while (m_p < 800) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    total++; if (enabled !== 1'b0) begin bad++; $display("FAIL midrst_enabled got=%b want=0", enabled); end
    total++; if (yuv_u !== 8'sd0 || yuv_v !== 8'sd0) begin bad++; $display("FAIL midrst_uv got=%0d/%0d want=0/0", yuv_u, yuv_v); end
    total++; if (even_line !== 1'b1) begin bad++; $display("FAIL midrst_even got=%b want=1", even_line); end
    total++; if (line_index !== 10'd0) begin bad++; $display("FAIL midrst_index got=%0d want=0", line_index); end
    for (int c = 0; c < 5; c++) tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    total++; if (line_index !== 10'd0) begin bad++; $display("FAIL midrst_nf_index got=%0d want=0", line_index); end
    total++; if (even_line !== 1'b1) begin bad++; $display("FAIL midrst_nf_even got=%b want=1", even_line); end
  endtask

  task automatic test_saturation();
    goto_line(50);
    for (int c = 0; c < 2300; c++) begin
      tick(1'b0, 1'b0, 1'b0);
      total++; if (enabled !== m_en) begin bad++; $display("FAIL sat_hcnt_enabled p=%0d got=%b want=%b", m_p, enabled, m_en); end
    end
    tick(1'b1, 1'b1, 1'b0);
    for (int l = 0; l < 1030; l++) begin
      tick(1'b1, 1'b0, 1'b0);
      total++; if (line_index !== m_idx) begin bad++; $display("FAIL sat_line_index l=%0d got=%0d want=%0d", l, line_index, m_idx); end
      total++; if (even_line !== m_even) begin bad++; $display("FAIL sat_even l=%0d got=%b want=%b", l, even_line, m_even); end
    end
  endtask

  task automatic test_random();
    for (int l = 0; l < 70; l++) begin
      int len;
      bit nf;
      bit rst;
      len = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 20)) : int'($urandom_range(100, 1700));
      nf  = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 29) == 0);
      tick(1'b1, nf, rst);
      for (int c = 0; c < len; c++) begin
        tick(1'b0, 1'b0, 1'b0);
        total++; if (enabled !== m_en) begin bad++; $display("FAIL rand_enabled p=%0d got=%b want=%b", m_p, enabled, m_en); end
        total++; if (yuv_u !== m_u) begin bad++; $display("FAIL rand_yuv_u p=%0d got=%0d want=%0d", m_p, yuv_u, m_u); end
        total++; if (yuv_v !== m_v) begin bad++; $display("FAIL rand_yuv_v p=%0d got=%0d want=%0d", m_p, yuv_v, m_v); end
        total++; if (even_line !== m_even) begin bad++; $display("FAIL rand_even got=%b want=%b", even_line, m_even); end
        total++; if (line_index !== m_idx) begin bad++; $display("FAIL rand_index got=%0d want=%0d", line_index, m_idx); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; line_start = 1'b0; newframe = 1'b0; yuv_u_in = '0; yuv_v_in = '0;
    m_p = 0; m_lines = 0; m_frames = 0;
    test_reset();
    test_line_window();
    test_blanked_line();
    test_parity();
    test_early_line_start();
    test_reset_mid_active();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
